// File: rtl/scs8hd_setb_sequencer.sv
// Drives the active-low SETB pins of NBANK set-flop banks: holds all banks in set
// during reset, then releases them one by one, and performs masked set pulses on request.
module scs8hd_setb_sequencer #(
   parameter int NBANK = 4,
   parameter int PW    = 2,
   parameter int GAP   = 1
) (
   input  logic             CLK,
   input  logic             RESETB,
   input  logic             REQ,
   input  logic [NBANK-1:0] MASK,
   output logic [NBANK-1:0] SETB_OUT,
   output logic             ACK,
   output logic             DONE,
   output logic             BUSY
);

   localparam int MAXC = (PW > GAP) ? PW : GAP;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   typedef enum logic [1:0] {HOLD, RELEASE, IDLE, ASSERT} state_t;

   state_t           state;
   logic [1:0]       rst_sync;
   logic [NBANK-1:0] rel_mask;
   logic [NBANK-1:0] next_bit;
   logic [CW-1:0]    cnt;
   logic             req_seq;

   function automatic logic [NBANK-1:0] lowest_bit(input logic [NBANK-1:0] m);
      return m & (~m + 1'b1);
   endfunction

   always_comb next_bit = lowest_bit(rel_mask);

   always_ff @(posedge CLK or negedge RESETB) begin
      if (!RESETB) rst_sync <= 2'b00;
      else         rst_sync <= {rst_sync[0], 1'b1};
   end

   // Every release edge sets the lowest pending bank and reloads the gap counter,
   // so the first release happens on the same edge that enters RELEASE.
   always_ff @(posedge CLK or negedge RESETB) begin
      if (!RESETB) begin
         state    <= HOLD;
         SETB_OUT <= '0;
         rel_mask <= '1;
         cnt      <= '0;
         req_seq  <= 1'b0;
         ACK      <= 1'b0;
         DONE     <= 1'b0;
         BUSY     <= 1'b1;
      end else begin
         ACK  <= 1'b0;
         DONE <= 1'b0;
         case (state)
            HOLD: begin
               if (rst_sync[1]) begin
                  SETB_OUT <= SETB_OUT | next_bit;
                  rel_mask <= rel_mask & ~next_bit;
                  cnt      <= CW'(GAP - 1);
                  req_seq  <= 1'b0;
                  state    <= RELEASE;
               end
            end
            RELEASE: begin
               if (rel_mask == '0) begin
                  DONE  <= req_seq;
                  BUSY  <= 1'b0;
                  state <= IDLE;
               end else if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  SETB_OUT <= SETB_OUT | next_bit;
                  rel_mask <= rel_mask & ~next_bit;
                  cnt      <= CW'(GAP - 1);
               end
            end
            IDLE: begin
               if (REQ) begin
                  ACK      <= 1'b1;
                  BUSY     <= 1'b1;
                  SETB_OUT <= SETB_OUT & ~MASK;
                  rel_mask <= MASK;
                  req_seq  <= 1'b1;
                  cnt      <= CW'(PW - 1);
                  state    <= (MASK == '0) ? RELEASE : ASSERT;
               end
            end
            ASSERT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  SETB_OUT <= SETB_OUT | next_bit;
                  rel_mask <= rel_mask & ~next_bit;
                  cnt      <= CW'(GAP - 1);
                  state    <= RELEASE;
               end
            end
            default: state <= HOLD;
         endcase
      end
   end

endmodule

// File: tb/tb_scs8hd_setb_sequencer.sv
// Directed bench for scs8hd_setb_sequencer: u0 uses PW=2/GAP=1, u1 uses PW=2/GAP=3.
module tb_scs8hd_setb_sequencer;

   logic       CLK = 1'b0;
   logic       RESETB = 1'b0;
   logic       REQ = 1'b0;
   logic [3:0] MASK = 4'b0000;

   logic [3:0] setb0, setb1;
   logic       ack0, done0, busy0, ack1, done1, busy1;

   typedef struct {
      string      tag;
      logic [6:0] v;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   sel = 0;

   always #5 CLK = ~CLK;

   scs8hd_setb_sequencer #(.NBANK(4), .PW(2), .GAP(1)) u0 (
      .CLK(CLK), .RESETB(RESETB), .REQ(REQ), .MASK(MASK),
      .SETB_OUT(setb0), .ACK(ack0), .DONE(done0), .BUSY(busy0)
   );

   scs8hd_setb_sequencer #(.NBANK(4), .PW(2), .GAP(3)) u1 (
      .CLK(CLK), .RESETB(RESETB), .REQ(REQ), .MASK(MASK),
      .SETB_OUT(setb1), .ACK(ack1), .DONE(done1), .BUSY(busy1)
   );

   function automatic logic [6:0] observed();
      return (sel == 0) ? {setb0, ack0, done0, busy0} : {setb1, ack1, done1, busy1};
   endfunction

   task automatic push(input string tag, input logic [3:0] s, input logic a, input logic d,
                       input logic b);
      exp_t e;
      e.tag = tag;
      e.v   = {s, a, d, b};
      q.push_back(e);
   endtask

   task automatic compare();
      exp_t       e;
      logic [6:0] o;
      e = q.pop_front();
      o = observed();
      total++;
      assert (o === e.v) else begin
         bad++;
         $error("FAIL %s observed setb/ack/done/busy=%b required=%b", e.tag, o, e.v);
      end
   endtask

   // apply inputs now, expect outputs after the next rising edge
   task automatic step(input string tag, input logic [3:0] s, input logic a, input logic d,
                       input logic b);
      push(tag, s, a, d, b);
      @(posedge CLK);
      #1;
      compare();
   endtask

   task automatic check_now(input string tag, input logic [3:0] s, input logic a, input logic d,
                            input logic b);
      push(tag, s, a, d, b);
      #1;
      compare();
   endtask

   task automatic power_on_gap1();
      RESETB = 1'b1;
      step("po_e0", 4'b0000, 0, 0, 1);
      step("po_e1", 4'b0000, 0, 0, 1);
      step("po_e2", 4'b0001, 0, 0, 1);
      step("po_e3", 4'b0011, 0, 0, 1);
      step("po_e4", 4'b0111, 0, 0, 1);
      step("po_e5", 4'b1111, 0, 0, 1);
      step("po_e6", 4'b1111, 0, 0, 0);
      step("po_e7", 4'b1111, 0, 0, 0);
   endtask

   initial begin
      logic [3:0] s;
      sel = 0;
      repeat (2) @(posedge CLK);
      #1;
      check_now("reset", 4'b0000, 0, 0, 1);
      power_on_gap1();

      // masked request with REQ held; MASK change during the sequence must be ignored
      REQ  = 1'b1;
      MASK = 4'b0101;
      step("rq_k",   4'b1010, 1, 0, 1);
      MASK = 4'b0010;
      step("rq_k1",  4'b1010, 0, 0, 1);
      step("rq_k2",  4'b1011, 0, 0, 1);
      step("rq_k3",  4'b1111, 0, 0, 1);
      step("rq_k4",  4'b1111, 0, 1, 0);
      step("rq_k5",  4'b1101, 1, 0, 1);
      REQ = 1'b0;
      step("rq_k6",  4'b1101, 0, 0, 1);
      step("rq_k7",  4'b1111, 0, 0, 1);
      step("rq_k8",  4'b1111, 0, 1, 0);
      step("rq_k9",  4'b1111, 0, 0, 0);

      // zero mask
      REQ  = 1'b1;
      MASK = 4'b0000;
      step("zm_k",   4'b1111, 1, 0, 1);
      REQ = 1'b0;
      step("zm_k1",  4'b1111, 0, 1, 0);
      step("zm_k2",  4'b1111, 0, 0, 0);

      // reset abort mid-release
      REQ  = 1'b1;
      MASK = 4'b1111;
      step("ab_k",   4'b0000, 1, 0, 1);
      REQ = 1'b0;
      step("ab_k1",  4'b0000, 0, 0, 1);
      step("ab_k2",  4'b0001, 0, 0, 1);
      RESETB = 1'b0;
      check_now("ab_async", 4'b0000, 0, 0, 1);
      step("ab_held", 4'b0000, 0, 0, 1);
      power_on_gap1();

      // GAP=3 instance: power-on, then full-mask request
      sel = 1;
      RESETB = 1'b0;
      check_now("g3_reset", 4'b0000, 0, 0, 1);
      step("g3_held", 4'b0000, 0, 0, 1);
      RESETB = 1'b1;
      for (int e = 0; e <= 13; e++) begin
         s = 4'b0000;
         for (int m = 0; m < 4; m++)
            if (2 + 3 * m <= e) s[m] = 1'b1;
         step($sformatf("g3_po_e%0d", e), s, 0, 0, (e < 12) ? 1'b1 : 1'b0);
      end
      REQ  = 1'b1;
      MASK = 4'b1111;
      for (int j = 0; j <= 13; j++) begin
         s = 4'b0000;
         for (int m = 0; m < 4; m++)
            if (2 + 3 * m <= j) s[m] = 1'b1;
         step($sformatf("g3_rq_k%0d", j), s, (j == 0) ? 1'b1 : 1'b0,
              (j == 12) ? 1'b1 : 1'b0, (j < 12) ? 1'b1 : 1'b0);
         REQ = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
